wb_regfile: RTL
===============

# wb_regfile

Parametrised write-back stage with integrated Y86-64 register file. It sits between the memory stage and decode: it takes one retiring instruction per cycle and derives the destinations from icode, rA, rB and the condition flag. It commits valE/valM into the register file and serves two combinational read ports with same-cycle write-through forwarding. It also keeps a sticky processor status and a retired-instruction counter.

## Interface
Parameters:
- DATA_W, 64, register and value width
- NREGS, 15, architectural registers; ids 0..NREGS-1 are valid, all-ones id is RNONE
- ID_W, 4, register id width (2**ID_W > NREGS)
- RSP_ID, 4, stack-pointer register id
- CNT_W, 32, retired-instruction counter width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- w_valid  in  1  a retiring instruction is presented this cycle
- w_icode  in  4  instruction code
- w_rA, w_rB  in  ID_W  register specifiers
- w_cnd  in  1  condition result (cmovXX)
- w_stat  in  3  instruction status: AOK=1, HLT=2, ADR=3, INS=4
- w_valE, w_valM  in  DATA_W  ALU result / memory read value
- rd_addr0, rd_addr1  in  ID_W  read addresses
- rd_data0, rd_data1  out  DATA_W  read data
- stat  out  3  processor status
- halted  out  1  stat != AOK
- retired  out  CNT_W  count of committed instructions

## Operation
- Destination decode, combinational:
  - cmovXX (2): dstE=rB if w_cnd, else RNONE.
  - irmovq (3), OPq (6): dstE=rB.
  - mrmovq (5): dstM=rA.
  - call (8), ret (9), pushq (A): dstE=RSP_ID.
  - popq (B): dstE=RSP_ID and dstM=rA.
  - All other icodes: no writes.
- Commit condition: commit = w_valid && !halted && w_stat==AOK.
- On commit, at the clk rising edge:
  - reg[dstE] <= w_valE if dstE != RNONE.
  - reg[dstM] <= w_valM if dstM != RNONE.
- Port conflict: if dstE==dstM, the M port wins. For popq %rsp, rsp = valM.
- Ids >= NREGS other than RNONE are ignored; no write occurs.
- Status: when w_valid && !halted && w_stat != AOK, stat <= w_stat. That instruction writes nothing and is not counted. Status is sticky until reset; once halted, all later inputs are ignored.
- retired increments by 1 per commit and wraps modulo 2**CNT_W.
- Reads:
  - RNONE or an out-of-range id returns 0.
  - Otherwise the read returns the register value, with forwarding.
  - Forwarding: if commit is active this cycle and rd_addr matches dstM, return w_valM. Else if it matches dstE, return w_valE. Else return the stored value.

## Timing
- Reset (async assert, sync release):
  - All registers 0.
  - stat = AOK (1), halted = 0, retired = 0.
  - rd_data reflects the zeroed file immediately.
- Write latency: a value is architecturally stored at the clk edge of commit. Forwarding makes it visible on the read ports in the same cycle, combinationally.
- Throughput: one instruction per cycle. There is no back-pressure; w_valid=0 is a bubble.
- Reset asserted mid-operation discards any in-flight commit. Nothing is written on the edge that coincides with reset assertion.
- Read paths are purely combinational from rd_addr and the w_* inputs; there is no clock on the read paths.
- The status update and the last commit cannot occur in the same cycle, because they are mutually exclusive by w_stat.

## Structure
- Shared package y86_pkg:
  - icode constants (IHALT..IPOPQ).
  - stat codes (SAOK, SHLT, SADR, SINS).
  - RNONE, RRSP.
- Sub-module wb_dst_decode (combinational icode/rA/rB/cnd -> dstE, dstM), reusable by decode-stage hazard logic.
- Storage, forwarding, status and counter logic stay in wb_regfile.

## Test plan
- Reset: after rst_n low then high, read every id -> 0; stat=1, halted=0, retired=0.
- irmovq rB=2, valE=0x1234 -> rd_data0 at addr 2 shows 0x1234 in the same cycle (forwarded) and after the edge (stored); retired=1.
- popq rA=4 (rsp), valE=0x108, valM=0xDEAD -> reg[4]=0xDEAD. Separately, popq rA=3, valE=0x108, valM=0x55 -> reg[4]=0x108, reg[3]=0x55.
- cmovXX rB=5, valE=7, cnd=0 -> reg[5] unchanged; with cnd=1 -> reg[5]=7.
- Instruction with w_stat=ADR (mrmovq rA=1) -> reg[1] unchanged, stat=3, halted=1. A following irmovq rB=1, valE=9 is ignored and retired stays constant.
- rst_n pulsed low while w_valid=1 with irmovq rB=6, valE=0xFF -> reg[6]=0 after release, retired=0.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 instruction codes, status codes and register ids
package y86_pkg;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;
endpackage

// File: rtl/wb_dst_decode.sv
// wb_dst_decode: maps a retiring instruction to its E and M write destinations
module wb_dst_decode
    import y86_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int RSP_ID = 4
) (
    input  logic [3:0]      icode,
    input  logic [ID_W-1:0] rA,
    input  logic [ID_W-1:0] rB,
    input  logic            cnd,
    output logic [ID_W-1:0] dstE,
    output logic [ID_W-1:0] dstM
);
    always_comb begin
        dstE = (icode == IRRMOVQ) ? (cnd ? rB : '1) :
               (icode == IIRMOVQ || icode == IOPQ) ? rB :
               (icode == ICALL || icode == IRET || icode == IPUSHQ || icode == IPOPQ) ? ID_W'(RSP_ID) : '1;
        dstM = (icode == IMRMOVQ || icode == IPOPQ) ? rA : '1;
    end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage with register file, forwarding read ports,
// sticky status and retired-instruction counter
module wb_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15,
    parameter int ID_W   = 4,
    parameter int RSP_ID = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_valid,
    input  logic [3:0]        w_icode,
    input  logic [ID_W-1:0]   w_rA,
    input  logic [ID_W-1:0]   w_rB,
    input  logic              w_cnd,
    input  logic [2:0]        w_stat,
    input  logic [DATA_W-1:0] w_valE,
    input  logic [DATA_W-1:0] w_valM,
    input  logic [ID_W-1:0]   rd_addr0,
    input  logic [ID_W-1:0]   rd_addr1,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    output logic [2:0]        stat,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);
    localparam logic [ID_W-1:0] NREGS_ID = ID_W'(NREGS);

    logic [DATA_W-1:0] regs [NREGS];
    logic [ID_W-1:0]   dstE, dstM;
    logic              commit, weE, weM;

    wb_dst_decode #(.ID_W(ID_W), .RSP_ID(RSP_ID)) dstDecode (
        .icode(w_icode),
        .rA   (w_rA),
        .rB   (w_rB),
        .cnd  (w_cnd),
        .dstE (dstE),
        .dstM (dstM)
    );

    assign halted = stat != SAOK;
    assign commit = w_valid && !halted && w_stat == SAOK;
    // RNONE is all-ones and never below NREGS, so one range check covers both
    assign weE = commit && dstE < NREGS_ID;
    assign weM = commit && dstM < NREGS_ID;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (weE) regs[dstE] <= w_valE;
            if (weM) regs[dstM] <= w_valM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat    <= SAOK;
            retired <= '0;
        end else if (w_valid && !halted && w_stat != SAOK) begin
            stat <= w_stat;
        end else if (commit) begin
            retired <= retired + 1'b1;
        end
    end

    // M port takes priority over E, matching the write ordering above
    function automatic logic [DATA_W-1:0] readPort(input logic [ID_W-1:0] addr);
        return (addr >= NREGS_ID) ? '0 :
               (commit && addr == dstM) ? w_valM :
               (commit && addr == dstE) ? w_valE : regs[addr];
    endfunction

    assign rd_data0 = readPort(rd_addr0);
    assign rd_data1 = readPort(rd_addr1);
endmodule
